trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
- Consumer side of the machine-mode CSR block: reads `mtvec`/`mepc` and turns ECALL and MRET in the execute stage into a pipeline flush plus fetch-PC redirect.
- Sits between the execute stage and the fetch PC mux.
- The CSR block records trap state (`mepc`, `mcause`); this block acts on that state.

Parameters:
- DRAIN, 2, number of flush cycles before the redirect; legal range 1..15; elaboration error outside that range.
- BOOT, 32'h00000000, reset value of `redirect_pc`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `valid`  in  1  `ir`/`pc` hold a live execute-stage instruction.
- `ir`  in  32  execute-stage instruction.
- `pc`  in  32  execute-stage PC.
- `mtvec`  in  32  trap vector from the CSR block.
- `mepc`  in  32  exception PC from the CSR block.
- `irq`  in  1  external interrupt request, level-sensitive; used only with TRAP_IRQ_EN.
- `flush`  out  1  kill younger pipeline stages.
- `stall`  out  1  hold fetch.
- `redirect`  out  1  one-cycle pulse; fetch loads `redirect_pc`.
- `redirect_pc`  out  32  redirect target.
- `irq_ack`  out  1  one-cycle interrupt-accepted pulse.
- `trap_cnt`  out  32  count of redirects issued.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: IDLE state; `flush`=0, `stall`=0, `redirect`=0, `irq_ack`=0, `redirect_pc`=BOOT, `trap_cnt`=0, handler flag=0.
- Decode: SYSTEM means `ir[6:2]`=5'b11100 and `ir[14:12]`=0.
  - ECALL: `ir[21]`=0.
  - MRET: `ir[21]`=1.
  - Other funct3 values (CSR ops) are ignored.
- FSM states: IDLE, DRAIN, REDIR.
- IDLE:
  - On `valid` and a SYSTEM instruction: latch kind (ECALL/MRET), load drain counter with DRAIN-1, go to DRAIN.
  - `flush` and `stall` rise in the next cycle, registered.
- DRAIN:
  - `flush`=1 and `stall`=1.
  - Counter decrements each cycle; `valid` and `ir` are ignored.
  - When the counter is 0, sample the target and go to REDIR:
    - ECALL: `mtvec` & ~32'h3.
    - MRET: `mepc`.
  - Sampling in the last DRAIN cycle is required so that CSR writes retired in the same or preceding cycle (including `mepc` written by the ECALL itself) are visible.
- REDIR:
  - `redirect`=1 for exactly one cycle with `redirect_pc` valid.
  - `flush`=1 and `stall`=0.
  - `trap_cnt` increments and wraps from 32'hFFFFFFFF to 0.
  - Return to IDLE.
- Latency: SYSTEM instruction accepted at cycle T → `redirect` asserted at cycle T+DRAIN+1.
- `redirect_pc` holds its last value between redirects.
- Boundaries:
  - `rst` asserted in any state → IDLE next cycle; no `redirect`; `trap_cnt` cleared.
  - `valid`=0 with a SYSTEM encoding on `ir` → no action.
  - A new SYSTEM instruction arriving during DRAIN or REDIR is dropped; flushed work is replayed by the pipeline.
  - Back-to-back ECALLs: the second is accepted only when it appears with `valid` in IDLE.

Optional Feature:
- Macro: TRAP_IRQ_EN.
- With TRAP_IRQ_EN:
  - Conditions: IDLE, `irq`=1, `valid`=1, current instruction not SYSTEM, handler flag=0.
  - Action: pulse `irq_ack`, set handler flag, follow the ECALL path with target `mtvec` & ~3.
  - ECALL/MRET take priority over `irq` in the same cycle.
  - MRET reaching REDIR clears the handler flag.
  - `irq` stays pending while the handler flag is 1.
- Without TRAP_IRQ_EN:
  - `irq` is unused; `irq_ack` is tied to 0; no handler flag.

Decomposition:
- Shared include (alongside the instruction-encoding header), which holds:
  - SYSTEM opcode constant.
  - FSM state encodings (IDLE=2'd0, DRAIN=2'd1, REDIR=2'd2).
  - ECALL/MRET kind bit.
- Sub-module: `trap_decode`, a purely combinational classifier. Inputs: `ir`, `valid`. Outputs: `is_ecall`, `is_mret`.
- FSM, counters and target latch stay in `trap_sequencer`.

Test Plan:
- Reset, then idle 5 cycles → `redirect_pc`=32'h00000000; `flush`, `stall` and `redirect` all 0; `trap_cnt`=0.
- DRAIN=2; ECALL (32'h00000073) with `valid` at T, `mtvec`=32'h00000103 →
  - `flush` and `stall` high at T+1 and T+2.
  - `redirect`=1 with `redirect_pc`=32'h00000100 at T+3.
  - `trap_cnt`=1.
- MRET (32'h30200073) at T; `mepc` changes 32'h40→32'h44 at T+1 → `redirect_pc`=32'h00000044 at T+3.
- ECALL at T with `rst` pulsed at T+2 → no `redirect` pulse; IDLE at T+3; `trap_cnt`=0.
- CSRRW (funct3=1) with `valid`, then ECALL with `valid`=0 → no `flush`, no `redirect`.
- TRAP_IRQ_EN set:
  - `irq`=1 with a non-SYSTEM `valid` instruction → `irq_ack` pulse, then redirect to `mtvec` & ~3.
  - A second `irq` while the handler flag is set → ignored until an MRET redirect has completed.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// rtl/trap_sequencer_pkg.sv - shared SYSTEM decode constants, FSM states and trap kind
package trap_sequencer_pkg;

  localparam logic [4:0] SYSTEM_OP     = 5'b11100;
  localparam logic [2:0] PRIV_FUNCT3   = 3'b000;
  localparam logic [31:0] VEC_ALIGN_MASK = ~32'h3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_REDIR = 2'd2
  } state_t;

  typedef enum logic {
    KIND_ECALL = 1'b0,
    KIND_MRET  = 1'b1
  } kind_t;

  // ECALL and MRET share opcode and funct3; everything else under SYSTEM is a CSR op.
  function automatic logic is_priv(input logic [31:0] ir);
    return (ir[6:2] == SYSTEM_OP) && (ir[14:12] == PRIV_FUNCT3);
  endfunction

endpackage

// File: rtl/trap_decode.sv
// rtl/trap_decode.sv - combinational ECALL/MRET classifier for the execute-stage instruction
module trap_decode
  import trap_sequencer_pkg::*;
(
  input  logic [31:0] ir,
  input  logic        valid,
  output logic        is_ecall,
  output logic        is_mret
);

  logic priv;
  logic unused_ir_bits;

  assign priv     = valid && is_priv(ir);
  assign is_ecall = priv && !ir[21];
  assign is_mret  = priv &&  ir[21];

  assign unused_ir_bits = ^{ir[31:22], ir[20:15], ir[11:7], ir[1:0]};

endmodule

// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - ECALL/MRET flush-and-redirect sequencer; optional interrupt entry under TRAP_IRQ_EN
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int          DRAIN = 2,
  parameter logic [31:0] BOOT  = 32'h00000000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [31:0] ir,
  input  logic [31:0] pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  input  logic        irq,
  output logic        flush,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        irq_ack,
  output logic [31:0] trap_cnt
);

  generate
    if (DRAIN < 1 || DRAIN > 15) begin : g_bad_drain
      $error("trap_sequencer: DRAIN must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN - 1);

  state_t      state, state_n;
  kind_t       kind;
  logic [3:0]  cnt;
  logic        is_ecall, is_mret;
  logic        take_sys, take_irq, fire;
  logic [31:0] target;

  trap_decode u_decode (
    .ir       (ir),
    .valid    (valid),
    .is_ecall (is_ecall),
    .is_mret  (is_mret)
  );

`ifdef TRAP_IRQ_EN
  logic handler;
  logic irq_ack_q;
  logic unused_inputs;

  // A SYSTEM instruction in the same cycle wins; the interrupt stays pending.
  assign take_irq      = irq && valid && !is_ecall && !is_mret && !handler;
  assign irq_ack       = irq_ack_q;
  assign unused_inputs = ^pc;
`else
  logic unused_inputs;

  assign take_irq      = 1'b0;
  assign irq_ack       = 1'b0;
  assign unused_inputs = ^{pc, irq};
`endif

  assign take_sys = is_ecall || is_mret;
  assign target   = (kind == KIND_MRET) ? mepc : (mtvec & VEC_ALIGN_MASK);

  always_comb begin
    state_n = state;
    fire    = 1'b0;
    case (state)
      ST_IDLE:  if (take_sys || take_irq) state_n = ST_DRAIN;
      ST_DRAIN: if (cnt == 4'd0) begin
                  state_n = ST_REDIR;
                  fire    = 1'b1;
                end
      ST_REDIR: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign flush    = (state != ST_IDLE);
  assign stall    = (state == ST_DRAIN);
  assign redirect = (state == ST_REDIR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      kind        <= KIND_ECALL;
      cnt         <= 4'd0;
      redirect_pc <= BOOT;
      trap_cnt    <= 32'd0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && (take_sys || take_irq)) begin
        kind <= is_mret ? KIND_MRET : KIND_ECALL;
        cnt  <= DRAIN_LOAD;
      end else if (state == ST_DRAIN && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // Target is taken in the last drain cycle so late CSR writes (mepc from the ECALL) land.
      if (fire) begin
        redirect_pc <= target;
        trap_cnt    <= trap_cnt + 32'd1;
      end
    end
  end

`ifdef TRAP_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      handler   <= 1'b0;
      irq_ack_q <= 1'b0;
    end else begin
      irq_ack_q <= (state == ST_IDLE) && take_irq;
      if (state == ST_IDLE && take_irq)
        handler <= 1'b1;
      else if (state == ST_REDIR && kind == KIND_MRET)
        handler <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// tb/tb_trap_sequencer.sv - directed self-checking bench for trap_sequencer (DRAIN=2)
module tb_trap_sequencer;

  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] MRET  = 32'h30200073;
  localparam logic [31:0] CSRRW = 32'h34011073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, valid, irq;
  logic [31:0] ir, pc, mtvec, mepc;
  logic        flush, stall, redirect, irq_ack;
  logic [31:0] redirect_pc, trap_cnt;

  int vectors = 0;
  int miscompares = 0;

  trap_sequencer #(.DRAIN(2), .BOOT(32'h00000000)) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .ir          (ir),
    .pc          (pc),
    .mtvec       (mtvec),
    .mepc        (mepc),
    .irq         (irq),
    .flush       (flush),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq_ack     (irq_ack),
    .trap_cnt    (trap_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic f, input logic s, input logic r);
    chk({tag, ".flush"},    {31'd0, flush},    {31'd0, f});
    chk({tag, ".stall"},    {31'd0, stall},    {31'd0, s});
    chk({tag, ".redirect"}, {31'd0, redirect}, {31'd0, r});
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; irq = 1'b0; ir = 32'h0; pc = 32'h1000;
    mtvec = 32'h0; mepc = 32'h0;
    step(); step();
    rst = 1'b0;
    repeat (5) step();
    outs("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.redirect_pc", redirect_pc, 32'h00000000);
    chk("reset.trap_cnt", trap_cnt, 32'd0);
    chk("reset.irq_ack", {31'd0, irq_ack}, 32'd0);

    // ECALL at T, mtvec low bits masked
    valid = 1'b1; ir = ECALL; mtvec = 32'h00000103;
    step(); valid = 1'b0; ir = NOP;
    outs("ecall.t1", 1'b1, 1'b1, 1'b0);
    step();
    outs("ecall.t2", 1'b1, 1'b1, 1'b0);
    step();
    outs("ecall.t3", 1'b1, 1'b0, 1'b1);
    chk("ecall.t3.redirect_pc", redirect_pc, 32'h00000100);
    step();
    outs("ecall.t4", 1'b0, 1'b0, 1'b0);
    chk("ecall.trap_cnt", trap_cnt, 32'd1);
    chk("ecall.hold_pc", redirect_pc, 32'h00000100);

    // MRET with mepc updated after acceptance
    mepc = 32'h40; valid = 1'b1; ir = MRET;
    step(); valid = 1'b0; ir = NOP; mepc = 32'h44;
    step();
    step();
    outs("mret.t3", 1'b1, 1'b0, 1'b1);
    chk("mret.t3.redirect_pc", redirect_pc, 32'h00000044);
    step();
    chk("mret.trap_cnt", trap_cnt, 32'd2);

    // SYSTEM instructions held during DRAIN are dropped
    mtvec = 32'h80000002; valid = 1'b1; ir = ECALL;
    step(); step(); step();
    valid = 1'b0; ir = NOP;
    outs("drop.t3", 1'b1, 1'b0, 1'b1);
    chk("drop.t3.redirect_pc", redirect_pc, 32'h80000000);
    step();
    outs("drop.t4", 1'b0, 1'b0, 1'b0);
    step();
    outs("drop.t5", 1'b0, 1'b0, 1'b0);
    chk("drop.trap_cnt", trap_cnt, 32'd3);

    // CSR op with valid, then ECALL encoding without valid
    valid = 1'b1; ir = CSRRW;
    step(); valid = 1'b0; ir = ECALL;
    step(); ir = NOP;
    outs("noact.t1", 1'b0, 1'b0, 1'b0);
    step();
    outs("noact.t2", 1'b0, 1'b0, 1'b0);
    step();
    outs("noact.t3", 1'b0, 1'b0, 1'b0);
    chk("noact.trap_cnt", trap_cnt, 32'd3);

    // Reset during DRAIN aborts the redirect
    valid = 1'b1; ir = ECALL;
    step(); valid = 1'b0; ir = NOP;
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    outs("rst.t3", 1'b0, 1'b0, 1'b0);
    chk("rst.trap_cnt", trap_cnt, 32'd0);
    chk("rst.redirect_pc", redirect_pc, 32'h00000000);
    step();
    outs("rst.t4", 1'b0, 1'b0, 1'b0);

`ifdef TRAP_IRQ_EN
    // Interrupt entry on a non-SYSTEM instruction
    mtvec = 32'h00000203; irq = 1'b1; valid = 1'b1; ir = NOP;
    step();
    chk("irq.t1.ack", {31'd0, irq_ack}, 32'd1);
    outs("irq.t1", 1'b1, 1'b1, 1'b0);
    step();
    chk("irq.t2.ack", {31'd0, irq_ack}, 32'd0);
    step();
    outs("irq.t3", 1'b1, 1'b0, 1'b1);
    chk("irq.t3.redirect_pc", redirect_pc, 32'h00000200);
    step();
    step();
    outs("irq.masked", 1'b0, 1'b0, 1'b0);
    chk("irq.masked.ack", {31'd0, irq_ack}, 32'd0);
    // MRET wins over the pending irq and clears the handler flag
    mepc = 32'h300; ir = MRET;
    step(); ir = NOP;
    chk("irq.mret.ack", {31'd0, irq_ack}, 32'd0);
    step();
    step();
    chk("irq.mret.redirect_pc", redirect_pc, 32'h00000300);
    step();
    step();
    chk("irq.reentry.ack", {31'd0, irq_ack}, 32'd1);
    chk("irq.trap_cnt", trap_cnt, 32'd2);
    irq = 1'b0; valid = 1'b0;
    step(); step(); step();
`else
    // irq has no effect without the interrupt feature
    irq = 1'b1; valid = 1'b1; ir = NOP;
    step();
    chk("irq_off.ack", {31'd0, irq_ack}, 32'd0);
    outs("irq_off", 1'b0, 1'b0, 1'b0);
    step();
    outs("irq_off.t2", 1'b0, 1'b0, 1'b0);
    irq = 1'b0; valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
